pe_csa_accumulator: RTL and testbench

- Downstream stage of the PE 4:2 compressor tree.
- Accepts one carry-save pair (sum, carry) per beat and folds it into a carry-save accumulator using one row of 4:2 compressor cells.
- On the last beat of a dot product, resolves the accumulator to binary with a chunked carry-propagate adder.
- Presents the result with a valid/ready handshake to the PE output register.

---
 rtl/pe_pkg.sv | 18 +
 rtl/csa4_2_row.sv | 29 ++
 rtl/pe_csa_accumulator.sv | 133 +++++++++++++
 tb/tb_pe_csa_accumulator.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and sizing for the PE accumulator stage: FSM states, default widths,
// and chunk-count helpers. Pure declarations, no latency, no flow control.
package pe_pkg;

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUT} state_t;

    localparam int ACC_W_DEF  = 32;
    localparam int CPA_W_DEF  = 8;
    localparam int NCHUNK_DEF = ACC_W_DEF / CPA_W_DEF;

    // Width of the chunk counter; a single-chunk build still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(NCHUNK_DEF);

endpackage

// File: rtl/csa4_2_row.sv
// One W-wide row of 4:2 compressor cells with the lateral c_in/c_out chain.
// Purely combinational, no backpressure. The carry output is already shifted up by one bit.
module csa4_2_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] s1;
    logic [W-1:0] cin;
    logic [W-2:0] cout;
    logic [W-2:0] cy;

    // c_out of a cell depends only on its own a,b,c, so the lateral chain never ripples.
    assign s1    = a_i ^ b_i ^ c_i;
    assign cout  = (a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0])
                 | (b_i[W-2:0] & c_i[W-2:0]);
    assign cin   = {cout, 1'b0};
    assign sum_o = s1 ^ d_i ^ cin;
    assign cy    = (s1[W-2:0] & d_i[W-2:0]) | (s1[W-2:0] & cin[W-2:0])
                 | (d_i[W-2:0] & cin[W-2:0]);
    assign carry_o = {cy, 1'b0};

endmodule

// File: rtl/pe_csa_accumulator.sv
// Carry-save accumulator with a chunked CPA. The result is valid NCHUNK+1 cycles after the last beat.
// in_ready is low outside ACCUM, and the result is held until out_ready.
module pe_csa_accumulator
    import pe_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CPA_W = CPA_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_sum,
    input  logic [ACC_W-1:0] in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    localparam int NCHUNK = ACC_W / CPA_W;
    localparam int CNT_W  = cnt_width(NCHUNK);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_s_q, acc_s_d;
    logic [ACC_W-1:0]   acc_c_q, acc_c_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               cpa_c_q, cpa_c_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   row_sum;
    logic [ACC_W-1:0]   row_carry;
    logic [CPA_W-1:0]   chunk_s;
    logic [CPA_W-1:0]   chunk_c;
    logic [CPA_W:0]     csum;

    csa4_2_row #(.W(ACC_W)) u_row (
        .a_i     (acc_s_q),
        .b_i     (acc_c_q),
        .c_i     (in_sum),
        .d_i     (in_carry),
        .sum_o   (row_sum),
        .carry_o (row_carry)
    );

    assign chunk_s   = acc_s_q[int'(cnt_q) * CPA_W +: CPA_W];
    assign chunk_c   = acc_c_q[int'(cnt_q) * CPA_W +: CPA_W];
    assign csum      = {1'b0, chunk_s} + {1'b0, chunk_c} + {{CPA_W{1'b0}}, cpa_c_q};

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        res_d       = res_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        cpa_c_d     = cpa_c_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_s_d = row_sum;
                    acc_c_d = row_carry;
                    if (in_last) begin
                        state_d = RESOLVE;
                        cnt_d   = '0;
                        cpa_c_d = 1'b0;
                        done_d  = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                // One chunk per cycle, then a final cycle to hand the resolved word to the output register.
                if (!done_q) begin
                    res_d[int'(cnt_q) * CPA_W +: CPA_W] = csum[CPA_W-1:0];
                    cpa_c_d = csum[CPA_W];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NCHUNK - 1)) begin
                        done_d = 1'b1;
                    end
                end else begin
                    out_data_d  = res_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_s_d     = '0;
                    acc_c_d     = '0;
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            res_q       <= '0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            cpa_c_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            res_q       <= res_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            cpa_c_q     <= cpa_c_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pe_csa_accumulator.sv
// Scoreboard bench for pe_csa_accumulator: directed scenarios followed by random dot products.
// Each expected result is the modular sum of sum+carry over the accepted beats of one dot product.
module tb_pe_csa_accumulator;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sum;
    logic [31:0] in_carry;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_acc;
    logic [31:0] exp_q[$];

    pe_csa_accumulator dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one beat and wait for it to be taken. The model is updated only on an actual fire.
    task automatic drive_beat(input logic [31:0] s, input logic [31:0] c,
                              input logic last, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited <= 200) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_accept: in_ready never rose within %0d cycles", waited);
            in_valid = 1'b0;
        end else begin
            @(negedge clock);
            in_valid  = 1'b0;
            model_acc = model_acc + s + c;
            if (last) begin
                exp_q.push_back(model_acc);
                model_acc = '0;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_acc = '0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h required 1 0 0 00000000",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_single();
        int k;
        logic [31:0] exp;
        out_ready = 1'b1;
        drive_beat(32'd5, 32'd3, 1'b1, 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k !== 5) begin
            failures++;
            $display("FAIL single_latency: out_valid after %0d cycles, required 5", k);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (out_data !== exp || out_data !== 32'd8) begin
            failures++;
            $display("FAIL single_data: out_data=%h required %h (8)", out_data, exp);
        end
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_return: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_multi();
        int k;
        logic [31:0] exp;
        out_ready = 1'b1;
        drive_beat(32'd100,     32'd20,     1'b0, 0);
        drive_beat(32'h0000_0F0F, 32'h0000_00F1, 1'b0, 1);
        drive_beat(32'd7,       32'd0,      1'b0, 0);
        drive_beat(32'd1,       32'd1,      1'b1, 2);
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL multi_busy: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (out_data !== exp || out_data !== 32'h0000_1081 || !out_valid) begin
            failures++;
            $display("FAIL multi_data: out_valid=%b out_data=%h required %h (00001081)", out_valid, out_data, exp);
        end
        @(negedge clock);
    endtask

    task automatic test_wrap();
        int k;
        logic [31:0] exp;
        out_ready = 1'b1;
        drive_beat(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        drive_beat(32'd2,         32'd0, 1'b1, 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (out_data !== exp || out_data !== 32'd2 || !out_valid) begin
            failures++;
            $display("FAIL wrap_data: out_valid=%b out_data=%h required %h (00000002)", out_valid, out_data, exp);
        end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        int k;
        logic [31:0] exp;
        out_ready = 1'b0;
        drive_beat(32'h1234_5678, 32'h0EDC_BA98, 1'b1, 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        // Offer a junk beat for the whole stall; it must not be absorbed.
        in_valid = 1'b1;
        in_sum   = 32'h0000_DEAD;
        in_carry = 32'h0000_0011;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: out_valid=%b out_data=%h in_ready=%b required 1 %h 0",
                         i, out_valid, out_data, in_ready, exp);
            end
            @(negedge clock);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        drive_beat(32'h0000_0055, 32'd0, 1'b1, 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (out_data !== exp || out_data !== 32'h55 || !out_valid) begin
            failures++;
            $display("FAIL stall_fresh: out_valid=%b out_data=%h required %h (00000055)", out_valid, out_data, exp);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_resolve();
        int k;
        int seen;
        logic [31:0] exp;
        out_ready = 1'b1;
        drive_beat(32'h0000_1234, 32'h0000_0010, 1'b1, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        model_acc = '0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: out_valid high for %0d cycles, required 0", seen);
        end
        drive_beat(32'd9, 32'd0, 1'b1, 0);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        checks++;
        if (out_data !== exp || out_data !== 32'd9 || !out_valid) begin
            failures++;
            $display("FAIL midreset_next: out_valid=%b out_data=%h required %h (00000009)", out_valid, out_data, exp);
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        localparam int NDOT = 1000;
        int got;
        int bad;
        int cyc;
        logic r;
        logic [31:0] exp;
        got = 0;
        bad = 0;
        cyc = 0;
        fork
            begin
                for (int d = 0; d < NDOT; d++) begin
                    int n;
                    n = $urandom_range(1, 16);
                    for (int j = 0; j < n; j++) begin
                        drive_beat($urandom(), $urandom(), (j == n - 1), $urandom_range(0, 2));
                    end
                end
            end
            begin
                while (got < NDOT && cyc < 60000) begin
                    r = 1'($urandom_range(0, 1));
                    out_ready = r;
                    if (out_valid && r) begin
                        got++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL random_extra: result %0d out_data=%h with no expected entry", got, out_data);
                        end else begin
                            exp = exp_q.pop_front();
                            if (out_data !== exp) begin
                                failures++;
                                bad++;
                                if (bad <= 10)
                                    $display("FAIL random_data[%0d]: out_data=%h required %h", got, out_data, exp);
                            end
                        end
                    end
                    @(negedge clock);
                    cyc++;
                end
                out_ready = 1'b1;
            end
        join
        checks++;
        if (got !== NDOT || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL random_count: received %0d results, %0d left pending, required %0d and 0",
                     got, exp_q.size(), NDOT);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_wrap();
        test_backpressure();
        test_reset_resolve();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
